// File: rtl/carrier_phase_nco.sv
// Carrier phase NCO: modulo-M phase accumulator with static offset, folded into a
// quarter-wave table address plus quadrant sign/swap flags for the I/Q rotator.
module carrier_phase_nco #(
  parameter int unsigned READ_DEPTH = 2500,
  parameter int unsigned NB_PHASE   = 14,
  parameter int unsigned NB_ADDR    = 12
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_sync,
  input  logic                i_freq_load,
  input  logic [NB_PHASE-1:0] i_freq_word,
  input  logic                i_offset_load,
  input  logic [NB_PHASE-1:0] i_phase_offset,
  output logic [NB_ADDR-1:0]  o_addr,
  output logic                o_swap,
  output logic                o_neg_sin,
  output logic                o_neg_cos,
  output logic [NB_PHASE-1:0] o_phase,
  output logic                o_valid
);

  localparam int unsigned         FullTurn = 4 * READ_DEPTH;
  localparam logic [NB_PHASE:0]   TurnExt  = (NB_PHASE + 1)'(FullTurn);
  localparam logic [NB_PHASE-1:0] TurnMax  = NB_PHASE'(FullTurn - 1);
  localparam logic [NB_PHASE-1:0] Quarter1 = NB_PHASE'(READ_DEPTH);
  localparam logic [NB_PHASE-1:0] Quarter2 = NB_PHASE'(2 * READ_DEPTH);
  localparam logic [NB_PHASE-1:0] Quarter3 = NB_PHASE'(3 * READ_DEPTH);

  function automatic logic [NB_PHASE-1:0] clamp_turn(input logic [NB_PHASE-1:0] w);
    return ({1'b0, w} >= TurnExt) ? TurnMax : w;
  endfunction

  // Both operands are below M, so one conditional subtract completes the modulo.
  function automatic logic [NB_PHASE-1:0] mod_add(input logic [NB_PHASE-1:0] a,
                                                  input logic [NB_PHASE-1:0] b);
    logic [NB_PHASE:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= TurnExt) sum = sum - TurnExt;
    return NB_PHASE'(sum);
  endfunction

  logic [NB_PHASE-1:0] step_q, offset_q, acc_q, acc_d, acc_cur;
  logic [NB_PHASE-1:0] ph1_q, ph1_d;
  logic                v1_q;
  logic [1:0]          quad;
  logic [NB_PHASE-1:0] fold;

  always_comb begin
    acc_cur = i_sync ? '0 : acc_q;
    acc_d   = acc_q;
    if (i_enable) begin
      acc_d = mod_add(acc_cur, step_q);
    end else if (i_sync) begin
      acc_d = '0;
    end
    ph1_d = mod_add(acc_cur, offset_q);
  end

  always_comb begin
    quad = 2'd0;
    fold = ph1_q;
    if (ph1_q >= Quarter3) begin
      quad = 2'd3;
      fold = ph1_q - Quarter3;
    end else if (ph1_q >= Quarter2) begin
      quad = 2'd2;
      fold = ph1_q - Quarter2;
    end else if (ph1_q >= Quarter1) begin
      quad = 2'd1;
      fold = ph1_q - Quarter1;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      step_q   <= '0;
      offset_q <= '0;
      acc_q    <= '0;
      ph1_q    <= '0;
      v1_q     <= 1'b0;
    end else begin
      if (i_freq_load)   step_q   <= clamp_turn(i_freq_word);
      if (i_offset_load) offset_q <= clamp_turn(i_phase_offset);
      acc_q <= acc_d;
      ph1_q <= ph1_d;
      v1_q  <= i_enable;
    end
  end

  // Data outputs hold their last sample while no new one arrives.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      o_addr    <= '0;
      o_swap    <= 1'b0;
      o_neg_sin <= 1'b0;
      o_neg_cos <= 1'b0;
      o_phase   <= '0;
      o_valid   <= 1'b0;
    end else begin
      o_valid <= v1_q;
      if (v1_q) begin
        o_addr    <= NB_ADDR'(fold);
        o_phase   <= ph1_q;
        o_swap    <= quad[0];
        o_neg_sin <= quad[1];
        o_neg_cos <= quad[0] ^ quad[1];
      end
    end
  end

endmodule

// File: tb/tb_carrier_phase_nco.sv
// Directed bench for carrier_phase_nco: ramp, quadrant folding, clamp, offset/sync,
// enable gaps and mid-run reset, with hand-computed expectations.
module tb_carrier_phase_nco;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic        sync = 1'b0;
  logic        freq_load = 1'b0;
  logic [13:0] freq_word = '0;
  logic        offset_load = 1'b0;
  logic [13:0] phase_offset = '0;
  logic [11:0] addr;
  logic        swap, neg_sin, neg_cos, valid;
  logic [13:0] phase;

  int checks = 0;
  int errors = 0;

  carrier_phase_nco #(
    .READ_DEPTH(2500),
    .NB_PHASE  (14),
    .NB_ADDR   (12)
  ) dut (
    .i_clock       (clk),
    .i_reset       (rst_n),
    .i_enable      (enable),
    .i_sync        (sync),
    .i_freq_load   (freq_load),
    .i_freq_word   (freq_word),
    .i_offset_load (offset_load),
    .i_phase_offset(phase_offset),
    .o_addr        (addr),
    .o_swap        (swap),
    .o_neg_sin     (neg_sin),
    .o_neg_cos     (neg_cos),
    .o_phase       (phase),
    .o_valid       (valid)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int v, input int p, input int a,
                         input int sw, input int ns, input int nc);
    chk({tag, ".valid"}, 32'(valid), 32'(v));
    chk({tag, ".phase"}, 32'(phase), 32'(p));
    chk({tag, ".addr"}, 32'(addr), 32'(a));
    chk({tag, ".swap"}, 32'(swap), 32'(sw));
    chk({tag, ".neg_sin"}, 32'(neg_sin), 32'(ns));
    chk({tag, ".neg_cos"}, 32'(neg_cos), 32'(nc));
  endtask

  initial begin
    int exp_off [6];
    exp_off = '{5000, 7500, 0, 2500, 5000, 7500};

    #12;
    chk_out("reset_state", 0, 0, 0, 0, 0, 0);
    #11 rst_n = 1'b1;

    // Ramp with step 1, offset 0
    freq_load = 1'b1; freq_word = 14'd1;
    offset_load = 1'b1; phase_offset = 14'd0;
    tick();
    freq_load = 1'b0; offset_load = 1'b0;
    enable = 1'b1;
    tick();
    chk("ramp.latency1", 32'(valid), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk_out($sformatf("ramp%0d", i), 1, i, i, 0, 0, 0);
    end
    tick(2494);
    chk_out("q0_end", 1, 2499, 2499, 0, 0, 0);
    tick();
    chk_out("q1_start", 1, 2500, 0, 1, 0, 1);
    tick(2500);
    chk_out("q2_start", 1, 5000, 0, 0, 1, 1);
    tick(4999);
    chk_out("turn_end", 1, 9999, 2499, 1, 1, 0);
    tick();
    chk_out("turn_wrap", 1, 0, 0, 0, 0, 0);

    // Clamped step 12000 -> 9999 (decrementing phase)
    enable = 1'b0; sync = 1'b1;
    freq_load = 1'b1; freq_word = 14'd12000;
    tick();
    sync = 1'b0; freq_load = 1'b0;
    tick(2);
    enable = 1'b1;
    tick();
    chk("clamp.latency1", 32'(valid), 0);
    tick();
    chk_out("clamp0", 1, 0, 0, 0, 0, 0);
    tick();
    chk_out("clamp1", 1, 9999, 2499, 1, 1, 0);
    tick();
    chk_out("clamp2", 1, 9998, 2498, 1, 1, 0);
    tick(2498);
    chk_out("clamp_7500", 1, 7500, 0, 1, 1, 0);

    // Offset 5000, step 2500
    enable = 1'b0; sync = 1'b1;
    freq_load = 1'b1; freq_word = 14'd2500;
    offset_load = 1'b1; phase_offset = 14'd5000;
    tick();
    sync = 1'b0; freq_load = 1'b0; offset_load = 1'b0;
    tick(2);
    enable = 1'b1;
    tick();
    chk("off.latency1", 32'(valid), 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("off%0d.phase", i), 32'(phase), 32'(exp_off[i]));
    end
    // Sync together with enable: the sample at this edge is offset only
    sync = 1'b1;
    tick();
    chk("sync_pre.phase", 32'(phase), 0);
    sync = 1'b0;
    tick();
    chk_out("sync_first", 1, 5000, 0, 0, 1, 1);
    tick();
    chk_out("sync_second", 1, 7500, 0, 1, 1, 0);

    // Enable gap: 1,0,1
    enable = 1'b0;
    tick();
    chk_out("gap_before", 1, 0, 0, 0, 0, 0);
    enable = 1'b1;
    tick();
    chk_out("gap_hold", 0, 0, 0, 0, 0, 0);
    tick();
    chk_out("gap_after", 1, 2500, 0, 1, 0, 1);
    tick();
    chk_out("gap_next", 1, 5000, 0, 0, 1, 1);

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1;
    chk_out("midreset", 0, 0, 0, 0, 0, 0);
    enable = 1'b0;
    tick();
    chk("midreset_held.valid", 32'(valid), 0);
    #2 rst_n = 1'b1;
    freq_load = 1'b1; freq_word = 14'd3;
    tick();
    freq_load = 1'b0;
    chk("post_reset.valid", 32'(valid), 0);
    enable = 1'b1;
    tick();
    chk("post_reset.latency1", 32'(valid), 0);
    tick();
    chk_out("post_reset0", 1, 0, 0, 0, 0, 0);
    tick();
    chk_out("post_reset1", 1, 3, 3, 0, 0, 0);
    tick();
    chk_out("post_reset2", 1, 6, 6, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/carrier_phase_nco.md
Name: carrier_phase_nco

Overview:
- Numerically controlled oscillator that feeds `top_phase_gen`, the carrier-offset rotator, directly upstream of it.
- Accumulates a programmable phase step modulo one full turn of 4*READ_DEPTH points.
- Folds the phase into a quarter-wave ROM address plus quadrant flags. These drive the quarter sin/cos tables and the I/Q rotator sign/swap logic.
- Fully pipelined: one phase sample per enabled cycle.

Parameters:
- READ_DEPTH, 2500: entries in each quarter-wave table (N). Full turn M = 4*N = 10000.
- NB_PHASE, 14: phase/step width. Must satisfy 2^NB_PHASE >= 4*READ_DEPTH.
- NB_ADDR, 12: ROM address width. Must satisfy 2^NB_ADDR >= READ_DEPTH.

Ports:
- i_clock  in  1  system clock, rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  1  request one phase sample this cycle; the accumulator advances.
- i_sync  in  1  synchronous phase restart: accumulator treated as 0 this cycle.
- i_freq_load  in  1  load i_freq_word into the step register.
- i_freq_word  in  NB_PHASE  unsigned phase step per sample.
- i_offset_load  in  1  load i_phase_offset into the offset register.
- i_phase_offset  in  NB_PHASE  unsigned static phase offset.
- o_addr  out  NB_ADDR  quarter-table index k, 0..N-1.
- o_swap  out  1  quadrant odd: rotator uses cos_q as sin and sin_q as cos.
- o_neg_sin  out  1  negate sin (quadrants 2,3).
- o_neg_cos  out  1  negate cos (quadrants 1,2).
- o_phase  out  NB_PHASE  full folded phase p, 0..M-1 (debug/verification).
- o_valid  out  1  outputs carry a new sample.

Behaviour:
- Reset (i_reset=0, async): accumulator, step, offset, pipeline regs, all outputs = 0.
- Register loads: step/offset clamp to M-1 if the loaded word >= M. A load takes effect from the next clock edge. If a load and i_enable coincide, that cycle's accumulation uses the old value.
- Accumulator A (NB_PHASE bits): on i_enable, A <= (A_cur + step) mod M, where A_cur = 0 if i_sync else A.
  - Wrap uses an NB_PHASE+1-bit sum: if sum >= M, subtract M. No division.
- i_sync without i_enable: A <= 0.
- i_enable=0: A holds.
- Stage 1 (registered every cycle):
  - ph1 <= (A_cur + offset) mod M, same wrap rule.
  - v1 <= i_enable.
- Stage 2 (output regs):
  - o_valid <= v1 every cycle.
  - When v1=1: derive quadrant q by comparing ph1 against N, 2N, 3N; k = ph1 - q*N.
  - Outputs: o_addr <= k, o_phase <= ph1, o_swap <= q[0], o_neg_sin <= (q>=2), o_neg_cos <= (q==1 or q==2).
  - When v1=0: data outputs hold the last values.
- Latency: a sample requested at cycle t appears at t+2 with o_valid=1.
- Sequence: the n-th enabled sample after reset/sync has p = (n*step + offset) mod M.
- Output mapping for the rotator:
  - sin = ±(swap ? cos_q[k] : sin_q[k]) with sign from o_neg_sin.
  - cos = ±(swap ? sin_q[k] : cos_q[k]) with sign from o_neg_cos.
- Step = M-1 is equivalent to -1: phase decreasing by one per sample.
- Reset mid-operation clears the pipeline; no stale valid appears after release.

Test Plan:
- Reset, step=1, offset=0, enable continuous:
  - o_valid rises 2 cycles after the first enable.
  - o_phase = 0,1,2,…; o_addr=o_phase for p<2500.
- Step=1, across p=2499→2500: o_addr 2499→0; o_swap 0→1; o_neg_cos 0→1; o_neg_sin stays 0.
- Step=1, across p=9999→0: o_addr 2499→0; flags (swap,neg_sin,neg_cos) go from (1,1,0) to (0,0,0).
- Load step=12000: clamped to 9999; phase sequence 0,9999,9998,…; p=7500 gives addr 0, swap=1, neg_sin=1, neg_cos=0.
- Offset=5000, step=2500:
  - Phases 5000,7500,0,2500 repeat.
  - Pulse i_sync with i_enable: that sample gives p=5000 (offset only) and the next gives 7500.
- Enable toggled 1,0,1:
  - o_valid pattern 1,0,1 delayed by 2; outputs hold during the gap.
  - Assert i_reset low mid-run: all outputs 0 immediately, o_valid=0 until 2 cycles after enable resumes.
